// File: rtl/spi_cmd_rx_pkg.sv
// Shared types and constants for the SPI command receiver.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

    localparam int SPI_FRAME_BITS = 8;

endpackage

// File: rtl/spi_cmd_rx_if.sv
// Pin-side and result-side signals of the SPI command receiver.
// Latency: none (wiring only).
// Backpressure: none; the SPI master cannot be stalled and results are strobes.
interface spi_cmd_rx_if import spi_rx_pkg::*; #(
    parameter int FRAME_BITS = SPI_FRAME_BITS
);
    logic                  sck;
    logic                  sdi;
    logic                  load;
    logic [FRAME_BITS-1:0] val;
    logic                  val_valid;
    logic                  frame_err;
    logic                  busy;

    // Drives the SPI pins and observes the receiver results.
    modport master (
        output sck, sdi, load,
        input  val, val_valid, frame_err, busy
    );

    // The receiver itself.
    modport slave (
        input  sck, sdi, load,
        output val, val_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_cmd_rx_sync_edge.sv
// Pin synchronizer with registered edge detection for one asynchronous input.
// Latency: q follows the pin after SYNC_STAGES clk edges; rise/fall are combinational from q.
// Backpressure: none.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    // Shift the pin through the synchronizer chain, then one more delay stage for edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            dly   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d_async};
            dly   <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~dly;
    assign fall = ~q & dly;
endmodule

// File: rtl/spi_cmd_rx.sv
// Assembles MSB-first SPI frames from raw pins and publishes the last well-formed frame.
// Latency: val/val_valid update SYNC_STAGES+2 clk edges after the load pin falls.
// Backpressure: none; the SPI master is never stalled, bad frames only raise frame_err.
module spi_cmd_rx import spi_rx_pkg::*; #(
    parameter int FRAME_BITS  = SPI_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    spi_cmd_rx_if.slave  bus
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic                  sck_rise;
    logic                  load_q;
    logic                  load_rise;
    logic                  load_fall;
    logic                  sdi_s;

    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic                  ovf;
    logic [FRAME_BITS-1:0] sr;
    logic                  rise_pend;
    logic [FRAME_BITS-1:0] val_r;
    logic                  val_valid_r;
    logic                  frame_err_r;
    logic                  busy_r;

    logic [SW-1:0]         settle;
    logic                  settled;
    logic                  armed;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .reset(reset), .d_async(bus.sck),
        .q(), .rise(sck_rise), .fall()
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
        .clk(clk), .reset(reset), .d_async(bus.load),
        .q(load_q), .rise(load_rise), .fall(load_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
        .clk(clk), .reset(reset), .d_async(bus.sdi),
        .q(sdi_s), .rise(), .fall()
    );

    // The sync chains come out of reset at 0, so a load pin already high at reset release
    // would look like a rise. Frames are only accepted once load has been seen low after the
    // chain holds genuine post-reset samples.
    assign settled = (settle == SW'(SYNC_STAGES));

    // Track chain settling after reset and arm frame starts once load is observed low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            if (!settled) begin
                settle <= settle + SW'(1);
            end
            if (settled && !load_q) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame FSM with counter, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ovf         <= 1'b0;
            sr          <= '0;
            rise_pend   <= 1'b0;
            val_r       <= '0;
            val_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            val_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    rise_pend <= 1'b0;
                    if ((load_rise && armed) || rise_pend) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        ovf    <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    // load fall wins; a coincident sck rise is dropped.
                    if (load_fall) begin
                        state  <= COMMIT;
                        busy_r <= 1'b0;
                    end else if (sck_rise) begin
                        sr <= {sr[FRAME_BITS-2:0], sdi_s};
                        if (cnt < CW'(FRAME_BITS)) begin
                            cnt <= cnt + CW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // A very short load gap can re-rise here; remember it for IDLE.
                    rise_pend <= load_rise;
                    if ((cnt == CW'(FRAME_BITS)) && !ovf) begin
                        val_r       <= sr;
                        val_valid_r <= 1'b1;
                    end else begin
                        frame_err_r <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.val       = val_r;
    assign bus.val_valid = val_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
endmodule
